sdram_avalon_bridge: RTL and testbench

Converts the custom logic's level-style SDRAM requests (read enable, write enable, 26-bit word address, 32-bit write data) into Avalon-MM master transactions with waitrequest/readdatavalid handshaking. It sits directly downstream of the custom-logic top level, between it and the SDRAM controller. It returns read data with a one-cycle valid pulse, which drives the top level's data and data-valid inputs. It enforces one outstanding transaction and flags controller hangs with a timeout.

---
 rtl/sdram_bridge_pkg.sv | 20 ++
 rtl/sdram_avalon_bridge_if.sv | 29 ++
 rtl/bridge_timeout_counter.sv | 44 ++++
 rtl/sdram_avalon_bridge.sv | 166 ++++++++++++++++
 tb/tb_sdram_avalon_bridge.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_bridge_pkg.sv
// Shared types and constants for the SDRAM Avalon-MM bridge.
//   bridge_state_t : bridge FSM state encoding (3 bits)
//   BYTEEN_ALL     : byte enable driven on every command (full 32-bit words)
//   BYTE_SHIFT     : word-to-byte address shift
//   DATA_W         : data path width
package sdram_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_CMD  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_RESP    = 3'd3,
        ST_WR_CMD  = 3'd4
    } bridge_state_t;

    localparam logic [3:0]  BYTEEN_ALL = 4'hF;
    localparam int unsigned BYTE_SHIFT = 2;
    localparam int unsigned DATA_W     = 32;

endpackage

// File: rtl/sdram_avalon_bridge_if.sv
// Avalon-MM master bus between the bridge and the SDRAM controller.
//   master modport : bridge side (drives address/read/write/writedata/byteenable)
//   slave modport  : controller side (drives waitrequest/readdata/readdatavalid)
interface sdram_avalon_bridge_if
    import sdram_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = 26
);

    logic [ADDR_W+BYTE_SHIFT-1:0] address;
    logic                         read;
    logic                         write;
    logic [DATA_W-1:0]            writedata;
    logic [3:0]                   byteenable;
    logic                         waitrequest;
    logic [DATA_W-1:0]            readdata;
    logic                         readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/bridge_timeout_counter.sv
// Counts cycles spent waiting for read data.
//   clk, n_rst  : clock, async active-low reset
//   clear_i     : reset count to zero
//   enable_i    : count this cycle
//   term_i      : terminal value (number of waiting cycles allowed)
//   terminal_c  : combinational, high in the enabled cycle that is the term_i-th one
module bridge_timeout_counter #(
    parameter int unsigned CNT_W = 10
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             terminal_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   cnt_inc;

    // cnt_q holds cycles already waited, so the current cycle is number cnt_q+1
    assign cnt_inc    = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign terminal_c = enable_i && (cnt_inc == {1'b0, term_i});

    // Next count: clear wins, stop advancing once terminal
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !terminal_c) begin
            cnt_d = cnt_inc[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sdram_avalon_bridge.sv
// Converts level-style read/write requests into single Avalon-MM transactions,
// one outstanding at a time, with a read-data timeout.
//   clk, n_rst            : clock, async active-low reset
//   cl_read_en/write_en   : level requests (write wins when both high in IDLE)
//   cl_address/writedata  : word address and write data, latched at acceptance
//   cl_readdata           : last read data (zero after a timeout)
//   cl_datareadvalid      : one-cycle pulse per completed read
//   cl_writedone          : one-cycle pulse per accepted write
//   busy                  : high whenever not IDLE
//   clear_err/timeout_err : sticky read-timeout flag and its clear
//   avm                   : Avalon-MM master bus
module sdram_avalon_bridge
    import sdram_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W  = 26,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 cl_read_en,
    input  logic                 cl_write_en,
    input  logic [ADDR_W-1:0]    cl_address,
    input  logic [DATA_W-1:0]    cl_writedata,
    output logic [DATA_W-1:0]    cl_readdata,
    output logic                 cl_datareadvalid,
    output logic                 cl_writedone,
    output logic                 busy,
    input  logic                 clear_err,
    output logic                 timeout_err,
    sdram_avalon_bridge_if.master avm
);

    localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    bridge_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              rvalid_q, rvalid_d;
    logic              wdone_q, wdone_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic              cnt_clear_c;
    logic              cnt_en_c;
    logic              cnt_expired_c;

    bridge_timeout_counter #(
        .CNT_W (CNT_W)
    ) u_timeout (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear_i    (cnt_clear_c),
        .enable_i   (cnt_en_c),
        .term_i     (CNT_W'(TIMEOUT)),
        .terminal_c (cnt_expired_c)
    );

    // Next-state and registered-output decode
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        wdone_d     = 1'b0;
        err_d       = err_q;
        cnt_clear_c = 1'b0;
        cnt_en_c    = 1'b0;

        if (clear_err) begin
            err_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cl_write_en) begin
                    addr_d  = cl_address;
                    wdata_d = cl_writedata;
                    state_d = ST_WR_CMD;
                end else if (cl_read_en) begin
                    addr_d  = cl_address;
                    state_d = ST_RD_CMD;
                end
            end
            ST_WR_CMD: begin
                if (!avm.waitrequest) begin
                    wdone_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_RD_CMD: begin
                if (!avm.waitrequest) begin
                    cnt_clear_c = 1'b1;
                    state_d     = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                cnt_en_c = 1'b1;
                if (avm.readdatavalid) begin
                    rdata_d  = avm.readdata;
                    rvalid_d = 1'b1;
                    state_d  = ST_RESP;
                end else if (cnt_expired_c) begin
                    // set overrides a same-cycle clear_err
                    err_d    = 1'b1;
                    rdata_d  = '0;
                    rvalid_d = 1'b1;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Command strobes and busy follow the state being entered
        rd_d   = (state_d == ST_RD_CMD);
        wr_d   = (state_d == ST_WR_CMD);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            rvalid_q <= 1'b0;
            wdone_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            rvalid_q <= rvalid_d;
            wdone_q  <= wdone_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign cl_readdata      = rdata_q;
    assign cl_datareadvalid = rvalid_q;
    assign cl_writedone     = wdone_q;
    assign busy             = busy_q;
    assign timeout_err      = err_q;

    assign avm.address    = {addr_q, {BYTE_SHIFT{1'b0}}};
    assign avm.read       = rd_q;
    assign avm.write      = wr_q;
    assign avm.writedata  = wdata_q;
    assign avm.byteenable = BYTEEN_ALL;

endmodule

// File: tb/tb_sdram_avalon_bridge.sv
// Scoreboard bench for sdram_avalon_bridge with a configurable controller model.
module tb_sdram_avalon_bridge;

    localparam int unsigned ADDR_W     = 26;
    localparam int unsigned TB_TIMEOUT = 15;

    logic              clk;
    logic              n_rst;
    logic              cl_read_en;
    logic              cl_write_en;
    logic [ADDR_W-1:0] cl_address;
    logic [31:0]       cl_writedata;
    logic [31:0]       cl_readdata;
    logic              cl_datareadvalid;
    logic              cl_writedone;
    logic              busy;
    logic              clear_err;
    logic              timeout_err;

    sdram_avalon_bridge_if #(.ADDR_W(ADDR_W)) avm_if ();

    sdram_avalon_bridge #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .cl_read_en       (cl_read_en),
        .cl_write_en      (cl_write_en),
        .cl_address       (cl_address),
        .cl_writedata     (cl_writedata),
        .cl_readdata      (cl_readdata),
        .cl_datareadvalid (cl_datareadvalid),
        .cl_writedone     (cl_writedone),
        .busy             (busy),
        .clear_err        (clear_err),
        .timeout_err      (timeout_err),
        .avm              (avm_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        is_read;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic is_read, input logic [31:0] data);
        exp_t e;
        e.is_read = is_read;
        e.data    = data;
        sb.push_back(e);
    endtask

    // Controller model configuration and statistics
    int          rd_wait_cfg = 0;
    int          wr_wait_cfg = 0;
    int          rdv_lat_cfg = 1;
    logic [31:0] rdata_cfg   = 32'h0;
    bit          respond_cfg = 1'b1;
    int          rd_acc      = 0;
    int          wr_acc      = 0;
    int          rvalid_cnt  = 0;

    // Controller model: waitrequest per command, readdatavalid a fixed number of cycles after acceptance
    initial begin
        int  wcnt;
        int  plat;
        bit  pending;
        wcnt    = 0;
        plat    = 0;
        pending = 1'b0;
        avm_if.waitrequest   = 1'b0;
        avm_if.readdata      = 32'h0;
        avm_if.readdatavalid = 1'b0;
        forever begin
            @(negedge clk);
            avm_if.readdatavalid = 1'b0;
            if (pending) begin
                plat--;
                if (plat <= 0) begin
                    pending              = 1'b0;
                    avm_if.readdatavalid = 1'b1;
                    avm_if.readdata      = rdata_cfg;
                end
            end
            if (avm_if.read || avm_if.write) begin
                if (wcnt < (avm_if.read ? rd_wait_cfg : wr_wait_cfg)) begin
                    avm_if.waitrequest = 1'b1;
                    wcnt++;
                end else begin
                    avm_if.waitrequest = 1'b0;
                    wcnt = 0;
                    if (avm_if.read) begin
                        rd_acc++;
                        if (respond_cfg) begin
                            pending = 1'b1;
                            plat    = rdv_lat_cfg;
                        end
                    end else begin
                        wr_acc++;
                    end
                end
            end else begin
                avm_if.waitrequest = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Monitor: every completion pulse is matched against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cl_datareadvalid) begin
                rvalid_cnt++;
                if (sb.size() == 0) begin
                    check("sb_unexpected_read_pulse", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_kind_read", 64'(e.is_read), 64'd1);
                    check("sb_rdata", 64'(cl_readdata), 64'(e.data));
                end
            end
            if (cl_writedone) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_writedone", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_kind_write", 64'(e.is_read), 64'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Waits for a pulse (0: datareadvalid, 1: writedone); returns cycles waited
    task automatic wait_pulse(input int which, input int maxc, output int m);
        m = 0;
        while (m < maxc) begin
            @(negedge clk);
            m++;
            if ((which == 0) ? cl_datareadvalid : cl_writedone) break;
        end
    endtask

    initial begin
        int m;
        int k;
        int base;
        int pulses;
        int wcycles;
        int stable_bad;

        n_rst        = 1'b0;
        cl_read_en   = 1'b0;
        cl_write_en  = 1'b0;
        cl_address   = '0;
        cl_writedata = '0;
        clear_err    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_read", 64'(avm_if.read), 64'd0);
        check("rst_write", 64'(avm_if.write), 64'd0);
        check("rst_rvalid", 64'(cl_datareadvalid), 64'd0);
        check("rst_wdone", 64'(cl_writedone), 64'd0);
        check("rst_err", 64'(timeout_err), 64'd0);
        check("rst_rdata", 64'(cl_readdata), 64'd0);
        check("rst_address", 64'(avm_if.address), 64'd0);
        check("rst_wdata", 64'(avm_if.writedata), 64'd0);
        check("byteenable", 64'(avm_if.byteenable), 64'hF);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // Read, no waitrequest, data 2 cycles after acceptance
        rd_wait_cfg = 0; rdv_lat_cfg = 2; rdata_cfg = 32'hDEADBEEF; respond_cfg = 1'b1;
        push_exp(1'b1, 32'hDEADBEEF);
        cl_read_en = 1'b1; cl_address = 26'h0000100;
        @(negedge clk);
        check("rd_strobe", 64'(avm_if.read), 64'd1);
        check("rd_address", 64'(avm_if.address), 64'h0000400);
        check("rd_busy", 64'(busy), 64'd1);
        cl_read_en = 1'b0; cl_address = 26'h3ABCDEF;
        wait_pulse(0, 40, k);
        check("rd_latency", 64'(1 + k), 64'd4);
        @(negedge clk);
        check("rd_pulse_once", 64'(cl_datareadvalid), 64'd0);
        check("rd_data_held", 64'(cl_readdata), 64'hDEADBEEF);
        check("rd_idle", 64'(busy), 64'd0);

        // Write with 3 cycles of waitrequest
        wr_wait_cfg = 3;
        push_exp(1'b0, 32'h0);
        base = wr_acc;
        cl_write_en = 1'b1; cl_address = 26'h2000000; cl_writedata = 32'h12345678;
        wcycles = 0; stable_bad = 0; m = 0;
        while (m < 40) begin
            @(negedge clk);
            m++;
            if (m == 1) begin
                cl_write_en = 1'b0; cl_address = 26'h0000011; cl_writedata = 32'h0;
            end
            if (avm_if.write) begin
                wcycles++;
                if (avm_if.address !== 28'h8000000 || avm_if.writedata !== 32'h12345678) stable_bad++;
            end
            if (cl_writedone) break;
        end
        check("wr_hold_cycles", 64'(wcycles), 64'd4);
        check("wr_stable", 64'(stable_bad), 64'd0);
        check("wr_done_latency", 64'(m), 64'd5);
        check("wr_accepts", 64'(wr_acc - base), 64'd1);
        wr_wait_cfg = 0;
        repeat (2) @(negedge clk);

        // Simultaneous read and write: write first, read in the following IDLE cycle
        rdv_lat_cfg = 1; rdata_cfg = 32'hA5A50001;
        push_exp(1'b0, 32'h0);
        push_exp(1'b1, 32'hA5A50001);
        cl_read_en = 1'b1; cl_write_en = 1'b1; cl_address = 26'h0000033; cl_writedata = 32'hCAFEF00D;
        @(negedge clk);
        check("both_write_first", 64'(avm_if.write), 64'd1);
        check("both_no_read", 64'(avm_if.read), 64'd0);
        cl_write_en = 1'b0;
        @(negedge clk);
        check("both_wdone", 64'(cl_writedone), 64'd1);
        @(negedge clk);
        check("both_read_next", 64'(avm_if.read), 64'd1);
        check("both_read_addr", 64'(avm_if.address), 64'h00000CC);
        cl_read_en = 1'b0;
        wait_pulse(0, 40, k);
        check("both_read_latency", 64'(3 + k), 64'd5);
        repeat (2) @(negedge clk);

        // Read enable held through RESP: back-to-back reads, one command per pulse
        rd_wait_cfg = 1; rdv_lat_cfg = 1; rdata_cfg = 32'h0BADF00D;
        repeat (3) push_exp(1'b1, 32'h0BADF00D);
        base = rd_acc; pulses = 0;
        cl_read_en = 1'b1; cl_address = 26'h0000040;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cl_datareadvalid) begin
                pulses++;
                if (pulses == 3) cl_read_en = 1'b0;
            end
        end
        check("b2b_pulses", 64'(pulses), 64'd3);
        check("b2b_commands", 64'(rd_acc - base), 64'd3);
        rd_wait_cfg = 0;

        // Reset while in RD_WAIT; a late readdatavalid is ignored
        rdv_lat_cfg = 6; rdata_cfg = 32'h00000077;
        cl_read_en = 1'b1; cl_address = 26'h0000005;
        @(negedge clk);
        cl_read_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_busy_before", 64'(busy), 64'd1);
        base = rvalid_cnt;
        n_rst = 1'b0;
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_read", 64'(avm_if.read), 64'd0);
        check("rst_mid_rdata", 64'(cl_readdata), 64'd0);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (12) @(negedge clk);
        check("rst_mid_no_pulse", 64'(rvalid_cnt - base), 64'd0);

        // Recovery read at the top word address
        rdv_lat_cfg = 1; rdata_cfg = 32'h13579BDF;
        push_exp(1'b1, 32'h13579BDF);
        cl_read_en = 1'b1; cl_address = 26'h3FFFFFF;
        @(negedge clk);
        check("max_address", 64'(avm_if.address), 64'hFFFFFFC);
        cl_read_en = 1'b0;
        wait_pulse(0, 40, k);
        check("recover_latency", 64'(1 + k), 64'd3);
        repeat (2) @(negedge clk);

        // Timeout: controller never responds
        respond_cfg = 1'b0;
        push_exp(1'b1, 32'h0);
        cl_read_en = 1'b1; cl_address = 26'h0000155;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            if (i == 1) cl_read_en = 1'b0;
            if (i == 16) check("to_err_not_yet", 64'(timeout_err), 64'd0);
            if (i == 17) begin
                check("to_err_set", 64'(timeout_err), 64'd1);
                check("to_pulse", 64'(cl_datareadvalid), 64'd1);
                check("to_rdata_zero", 64'(cl_readdata), 64'd0);
            end
        end
        repeat (2) @(negedge clk);
        check("to_err_sticky", 64'(timeout_err), 64'd1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("to_err_cleared", 64'(timeout_err), 64'd0);

        // Second timeout with clear_err held: set wins in the expiry cycle
        push_exp(1'b1, 32'h0);
        clear_err = 1'b1;
        cl_read_en = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            if (i == 1) cl_read_en = 1'b0;
            if (i == 17) check("to_set_beats_clear", 64'(timeout_err), 64'd1);
        end
        @(negedge clk);
        check("to_clear_after", 64'(timeout_err), 64'd0);
        clear_err = 1'b0;
        respond_cfg = 1'b1;
        repeat (3) @(negedge clk);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
